// File: rtl/apb_seg_scan_ctrl_if.sv
// rtl/apb_seg_scan_ctrl_if.sv - APB bus bundle for the segment scan controller
//
// Purpose: groups the APB slave signals of apb_seg_scan_ctrl.
// Signals:
//   PADDR   [7:0]  byte address
//   PSEL           slave select
//   PENABLE        access phase
//   PWRITE         1 = write
//   PWDATA  [31:0] write data
//   PRDATA  [31:0] read data (slave drives)
//   PREADY         always 1 (slave drives)
// Modports: master (bus driver), slave (peripheral).

interface apb_seg_scan_ctrl_if;
   logic [7:0]  PADDR;
   logic        PSEL;
   logic        PENABLE;
   logic        PWRITE;
   logic [31:0] PWDATA;
   logic [31:0] PRDATA;
   logic        PREADY;

   modport master (
      output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      input  PRDATA, PREADY
   );

   modport slave (
      input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
      output PRDATA, PREADY
   );
endinterface

// File: rtl/apb_seg_scan_ctrl.sv
// rtl/apb_seg_scan_ctrl.sv - APB multiplexed 7-segment scan controller with LED bank
//
// Purpose: scans NUM_DIGITS digits one slot (CLK_DIV cycles) at a time, with
// hex-decode or raw segments, PWM brightness, per-digit blink and an LED bank.
// Ports:
//   PCLK     sole clock
//   PRESETn  asynchronous active-low reset
//   apb      APB slave (PADDR/PSEL/PENABLE/PWRITE/PWDATA/PRDATA/PREADY)
//   SEGOUT   [7:0] segments a..g in bits 0..6, dp in bit 7 (registered)
//   SEGCOM   [NUM_DIGITS-1:0] digit enables (registered)
//   LED_OUT  [7:0] LED bank (registered)
// Registers: 0x00 CTRL, 0x04 BLINK_MASK, 0x08 LED, 0x0C STATUS (RO),
//            0x10+4*i DIGIT_i.

module apb_seg_scan_ctrl #(
   parameter int NUM_DIGITS     = 8,
   parameter int CLK_DIV        = 1000,
   parameter int PWM_BITS       = 4,
   parameter int BLINK_SHIFT    = 5,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit COM_ACTIVE_LOW = 1'b1
) (
   input  logic                  PCLK,
   input  logic                  PRESETn,
   apb_seg_scan_ctrl_if.slave    apb,
   output logic [7:0]            SEGOUT,
   output logic [NUM_DIGITS-1:0] SEGCOM,
   output logic [7:0]            LED_OUT
);

   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PRE_W = $clog2(CLK_DIV);
   // Wide enough for (2^PWM_BITS) * CLK_DIV with a 32-bit CLK_DIV.
   localparam int OT_W  = PWM_BITS + 33;
   localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] COM_OFF = COM_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : '0;

   // Register file
   logic                ctrl_en;
   logic                ctrl_decode;
   logic                ctrl_blink_en;
   logic [PWM_BITS-1:0] ctrl_bright;
   logic [NUM_DIGITS-1:0] blink_mask;
   logic [7:0]          led_reg;
   logic [7:0]          digit_reg [NUM_DIGITS];

   // Scan state
   logic [PRE_W-1:0]    presc;
   logic [IDX_W-1:0]    idx;
   logic [15:0]         frame_cnt;

   // Output registers
   logic [7:0]            seg_q;
   logic [NUM_DIGITS-1:0] com_q;
   logic [7:0]            led_q;

   // Address decode (word-aligned addresses only)
   logic       aligned;
   logic       sel_ctrl, sel_mask, sel_led, sel_status, sel_digit;
   logic [5:0] digit_sel;
   logic       wr_en;

   assign aligned    = (apb.PADDR[1:0] == 2'b00);
   assign sel_ctrl   = aligned && (apb.PADDR[7:2] == 6'd0);
   assign sel_mask   = aligned && (apb.PADDR[7:2] == 6'd1);
   assign sel_led    = aligned && (apb.PADDR[7:2] == 6'd2);
   assign sel_status = aligned && (apb.PADDR[7:2] == 6'd3);
   assign digit_sel  = apb.PADDR[7:2] - 6'd4;
   assign sel_digit  = aligned && (apb.PADDR[7:2] >= 6'd4) && (int'(digit_sel) < NUM_DIGITS);
   assign wr_en      = apb.PSEL & apb.PENABLE & apb.PWRITE;

   logic unused_ok;
   assign unused_ok = &{1'b0, apb.PWDATA};

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         ctrl_en       <= 1'b0;
         ctrl_decode   <= 1'b0;
         ctrl_blink_en <= 1'b0;
         ctrl_bright   <= '0;
         blink_mask    <= '0;
         led_reg       <= '0;
         for (int i = 0; i < NUM_DIGITS; i++) digit_reg[i] <= '0;
      end else if (wr_en) begin
         if (sel_ctrl) begin
            ctrl_en       <= apb.PWDATA[0];
            ctrl_decode   <= apb.PWDATA[1];
            ctrl_blink_en <= apb.PWDATA[2];
            ctrl_bright   <= apb.PWDATA[8 +: PWM_BITS];
         end
         if (sel_mask) blink_mask <= apb.PWDATA[NUM_DIGITS-1:0];
         if (sel_led)  led_reg    <= apb.PWDATA[7:0];
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_digit && (digit_sel == 6'(i))) digit_reg[i] <= apb.PWDATA[7:0];
         end
      end
   end

   // Scan counters: prescaler -> digit index -> frame counter.
   logic presc_wrap, idx_wrap;
   assign presc_wrap = (presc == PRE_W'(CLK_DIV - 1));
   assign idx_wrap   = (idx == IDX_W'(NUM_DIGITS - 1));

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         presc     <= '0;
         idx       <= '0;
         frame_cnt <= '0;
      end else if (!ctrl_en) begin
         presc     <= '0;
         idx       <= '0;
         frame_cnt <= '0;
      end else if (presc_wrap) begin
         presc <= '0;
         if (idx_wrap) begin
            idx       <= '0;
            frame_cnt <= frame_cnt + 16'd1;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      case (v)
         4'h0: hex_seg = 7'h3F;
         4'h1: hex_seg = 7'h06;
         4'h2: hex_seg = 7'h5B;
         4'h3: hex_seg = 7'h4F;
         4'h4: hex_seg = 7'h66;
         4'h5: hex_seg = 7'h6D;
         4'h6: hex_seg = 7'h7D;
         4'h7: hex_seg = 7'h07;
         4'h8: hex_seg = 7'h7F;
         4'h9: hex_seg = 7'h6F;
         4'hA: hex_seg = 7'h77;
         4'hB: hex_seg = 7'h7C;
         4'hC: hex_seg = 7'h39;
         4'hD: hex_seg = 7'h5E;
         4'hE: hex_seg = 7'h79;
         default: hex_seg = 7'h71;
      endcase
   endfunction

   // Current-digit selection; the one-hot enable comes from the same index so
   // SEGCOM can never have more than one bit active.
   logic [7:0]            cur_digit;
   logic                  cur_blink;
   logic [NUM_DIGITS-1:0] com_on;

   always_comb begin
      cur_digit = '0;
      cur_blink = 1'b0;
      com_on    = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == IDX_W'(i)) begin
            cur_digit = digit_reg[i];
            cur_blink = blink_mask[i];
            com_on[i] = 1'b1;
         end
      end
   end

   logic [OT_W-1:0] on_time;
   logic            blink_dark;
   logic            lit;
   logic [7:0]      seg_on;

   assign on_time    = ((OT_W'(ctrl_bright) + OT_W'(1)) * OT_W'(CLK_DIV)) >> PWM_BITS;
   assign blink_dark = ctrl_blink_en & cur_blink & frame_cnt[BLINK_SHIFT];
   assign lit        = ctrl_en & (OT_W'(presc) < on_time) & ~blink_dark;
   assign seg_on     = ctrl_decode ? {cur_digit[7], hex_seg(cur_digit[3:0])} : cur_digit;

   // SEGOUT and SEGCOM share one register stage so they switch together.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         seg_q <= SEG_OFF;
         com_q <= COM_OFF;
         led_q <= '0;
      end else begin
         seg_q <= lit ? (SEG_ACTIVE_LOW ? ~seg_on : seg_on) : SEG_OFF;
         com_q <= lit ? (COM_ACTIVE_LOW ? ~com_on : com_on) : COM_OFF;
         led_q <= led_reg;
      end
   end

   assign SEGOUT  = seg_q;
   assign SEGCOM  = com_q;
   assign LED_OUT = led_q;

   // Read mux
   logic [31:0] rd_data;

   always_comb begin
      rd_data = '0;
      if (sel_ctrl) begin
         rd_data[0]              = ctrl_en;
         rd_data[1]              = ctrl_decode;
         rd_data[2]              = ctrl_blink_en;
         rd_data[8 +: PWM_BITS]  = ctrl_bright;
      end
      if (sel_mask)   rd_data[NUM_DIGITS-1:0] = blink_mask;
      if (sel_led)    rd_data[7:0]            = led_reg;
      if (sel_status) rd_data = {frame_cnt, 12'd0, 4'(idx)};
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (sel_digit && (digit_sel == 6'(i))) rd_data[7:0] = digit_reg[i];
      end
   end

   assign apb.PRDATA = (apb.PSEL & ~apb.PWRITE) ? rd_data : 32'd0;
   assign apb.PREADY = 1'b1;

endmodule

// File: tb/tb_apb_seg_scan_ctrl.sv
// tb/tb_apb_seg_scan_ctrl.sv - directed self-checking bench for apb_seg_scan_ctrl

module tb_apb_seg_scan_ctrl;

   logic       PCLK = 1'b0;
   logic       PRESETn;
   logic [7:0] SEGOUT;
   logic [3:0] SEGCOM;
   logic [7:0] LED_OUT;

   int n_assert = 0;
   int n_fail   = 0;

   apb_seg_scan_ctrl_if bus ();

   apb_seg_scan_ctrl #(
      .NUM_DIGITS(4), .CLK_DIV(16), .PWM_BITS(4), .BLINK_SHIFT(1),
      .SEG_ACTIVE_LOW(1'b1), .COM_ACTIVE_LOW(1'b1)
   ) dut (
      .PCLK    (PCLK),
      .PRESETn (PRESETn),
      .apb     (bus),
      .SEGOUT  (SEGOUT),
      .SEGCOM  (SEGCOM),
      .LED_OUT (LED_OUT)
   );

   always #5 PCLK = ~PCLK;

   // Expected-state model
   logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
   logic [7:0] m_digit [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
   logic [3:0] m_mask   = 4'h0;
   int         m_bright = 0;
   logic       m_decode = 1'b0;
   logic       m_blink  = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
      @(posedge PCLK); #1;
      bus.PADDR = a; bus.PWDATA = d; bus.PWRITE = 1'b1; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      @(posedge PCLK); #1;
      bus.PENABLE = 1'b1;
      @(posedge PCLK); #1;
      bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
      bus.PADDR = a; bus.PWRITE = 1'b0; bus.PSEL = 1'b1; bus.PENABLE = 1'b0;
      #1;
      d = bus.PRDATA;
      bus.PSEL = 1'b0;
   endtask

   // Returns on the cycle after the enabling CTRL write; k counts edges after it.
   task automatic run_check(input string tag, input int n);
      logic [31:0] rd;
      logic [7:0]  d, seg;
      int p, s, f, on;
      logic lit;
      chk({tag, "_first_edge_off"}, {28'd0, SEGCOM}, 32'hF);
      on = ((m_bright + 1) * 16) >> 4;
      for (int k = 1; k <= n; k++) begin
         @(posedge PCLK); #1;
         p = (k - 1) % 16;
         s = ((k - 1) / 16) % 4;
         f = (k - 1) / 64;
         lit = (p < on) && !(m_blink && m_mask[s] && (((f >> 1) & 1) == 1));
         d = m_digit[s];
         seg = m_decode ? {d[7], hex_tbl[d[3:0]]} : d;
         chk({tag, "_segcom"}, {28'd0, SEGCOM}, lit ? {28'd0, ~(4'b0001 << s)} : 32'hF);
         chk({tag, "_segout"}, {24'd0, SEGOUT}, lit ? {24'd0, ~seg} : 32'hFF);
         apb_read(8'h0C, rd);
         chk({tag, "_status"}, rd, {16'(k / 64), 12'd0, 4'((k / 16) % 4)});
      end
   endtask

   task automatic restart(input logic [31:0] ctrl);
      apb_write(8'h00, 32'h0);
      apb_write(8'h00, ctrl);
      m_decode = ctrl[1];
      m_blink  = ctrl[2];
      m_bright = int'(ctrl[11:8]);
   endtask

   logic [31:0] rd;

   initial begin
      bus.PADDR = '0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PWDATA = '0;
      PRESETn = 1'b1;
      #2 PRESETn = 1'b0;
      #1;
      chk("rst_segout", {24'd0, SEGOUT}, 32'hFF);
      chk("rst_segcom", {28'd0, SEGCOM}, 32'hF);
      chk("rst_led",    {24'd0, LED_OUT}, 32'h0);
      repeat (3) @(posedge PCLK);
      #1 PRESETn = 1'b1;
      apb_read(8'h00, rd); chk("rst_ctrl_rd", rd, 32'h0);
      apb_read(8'h0C, rd); chk("rst_status_rd", rd, 32'h0);

      // Decode, full brightness
      apb_write(8'h10, 32'h03); m_digit[0] = 8'h03;
      apb_write(8'h00, 32'hF03);
      m_decode = 1'b1; m_blink = 1'b0; m_bright = 15;
      run_check("full", 64);

      // Half brightness
      restart(32'h703);
      run_check("half", 64);

      // Raw mode and LED
      apb_write(8'h14, 32'h80); m_digit[1] = 8'h80;
      restart(32'hF01);
      run_check("raw", 64);
      apb_write(8'h08, 32'hA5);
      chk("led_latency", {24'd0, LED_OUT}, 32'h00);
      @(posedge PCLK); #1;
      chk("led_out", {24'd0, LED_OUT}, 32'hA5);

      // Blink on digit 0
      apb_write(8'h04, 32'h1); m_mask = 4'h1;
      restart(32'hF07);
      run_check("blink", 512);

      // Readbacks and ignored unmapped write
      apb_write(8'h50, 32'hDEAD_BEEF);
      apb_read(8'h50, rd); chk("unmapped_wr_rd", rd, 32'h0);
      apb_read(8'h14, rd); chk("digit1_rd", rd, 32'h80);
      apb_read(8'h04, rd); chk("mask_rd", rd, 32'h1);
      apb_read(8'h00, rd); chk("ctrl_rd", rd, 32'hF07);
      apb_read(8'h08, rd); chk("led_rd", rd, 32'hA5);

      // Clearing EN blanks and zeroes counters, LED keeps following
      apb_write(8'h00, 32'h0);
      @(posedge PCLK); #1;
      chk("en_clr_segcom", {28'd0, SEGCOM}, 32'hF);
      chk("en_clr_segout", {24'd0, SEGOUT}, 32'hFF);
      chk("en_clr_led", {24'd0, LED_OUT}, 32'hA5);
      apb_read(8'h0C, rd); chk("en_clr_status", rd, 32'h0);

      // Asynchronous reset in the middle of a lit slot
      apb_write(8'h00, 32'hF03);
      repeat (5) @(posedge PCLK);
      #1;
      chk("pre_rst_lit", {28'd0, SEGCOM}, 32'hE);
      #2 PRESETn = 1'b0;
      #1;
      chk("mid_rst_segcom", {28'd0, SEGCOM}, 32'hF);
      chk("mid_rst_segout", {24'd0, SEGOUT}, 32'hFF);
      chk("mid_rst_led",    {24'd0, LED_OUT}, 32'h0);
      @(posedge PCLK); #1 PRESETn = 1'b1;
      apb_read(8'h50, rd); chk("unmapped_rd", rd, 32'h0);
      apb_read(8'h00, rd); chk("post_rst_ctrl", rd, 32'h0);
      apb_read(8'h10, rd); chk("post_rst_digit0", rd, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
